serial_adder_ctrl: RTL

Bit-serial adder controller that sequences a single one-bit full-adder slice, built from two `half_adder` instances, to add two WIDTH-bit operands, LSB first, one bit per clock. It is the first sequential consumer of the `half_adder` datapath. The block captures operands on a start handshake, runs the slice for WIDTH cycles with a registered carry, then presents the sum and carry-out with a one-cycle done pulse. The serial slice trades WIDTH cycles of latency for WIDTH-fold less adder hardware.

---
 rtl/serial_adder_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder slice (two half adders) adds two WIDTH-bit operands LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    // Single-bit add without carry-in
    always_comb begin
        s = a ^ b;
        c = a & b;
    end

endmodule

module serial_adder_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic busy,
    input logic done
);

    ast_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(busy && done));
    ast_done_pulse:     assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] sa_r, sa_s;
    logic [WIDTH-1:0] sb_r, sb_s;
    logic [WIDTH-1:0] ss_r, ss_s;
    logic [WIDTH-1:0] ss_shift_s;
    logic [WIDTH-1:0] sum_r, sum_s;
    logic             c_r, c_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             cout_r, cout_s;
    logic             busy_r, done_r;
    logic             s1_s, c1_s, bit_s, c2_s, carry_next_s;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_r, ovf_s;
`endif

    half_adder u_ha1 (
        .a (sa_r[0]),
        .b (sb_r[0]),
        .s (s1_s),
        .c (c1_s)
    );

    half_adder u_ha2 (
        .a (s1_s),
        .b (c_r),
        .s (bit_s),
        .c (c2_s)
    );

    // Carry out of the slice and the sum register with the new bit entering at the MSB
    always_comb begin
        carry_next_s            = c1_s | c2_s;
        ss_shift_s              = ss_r >> 1'b1;
        ss_shift_s[WIDTH-1]     = bit_s;
    end

    // Next-state and datapath update
    always_comb begin
        state_s = state_r;
        sa_s    = sa_r;
        sb_s    = sb_r;
        ss_s    = ss_r;
        c_s     = c_r;
        cnt_s   = cnt_r;
        sum_s   = sum_r;
        cout_s  = cout_r;
`ifdef SERIAL_ADD_OVF_EN
        ovf_s   = ovf_r;
`endif
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    sa_s    = a;
                    sb_s    = b;
                    ss_s    = '0;
                    c_s     = 1'b0;
                    cnt_s   = '0;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                sa_s  = sa_r >> 1'b1;
                sb_s  = sb_r >> 1'b1;
                ss_s  = ss_shift_s;
                c_s   = carry_next_s;
                cnt_s = cnt_r + CW'(1'b1);
                if (cnt_r == CW'(WIDTH - 1)) begin
                    // c_r is the carry into the MSB on this last bit
                    sum_s   = ss_shift_s;
                    cout_s  = carry_next_s;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_s   = c_r ^ carry_next_s;
`endif
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            sa_r    <= '0;
            sb_r    <= '0;
            ss_r    <= '0;
            c_r     <= 1'b0;
            cnt_r   <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            sa_r    <= sa_s;
            sb_r    <= sb_s;
            ss_r    <= ss_s;
            c_r     <= c_s;
            cnt_r   <= cnt_s;
            sum_r   <= sum_s;
            cout_r  <= cout_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
`ifdef SERIAL_ADD_OVF_EN
            ovf_r   <= ovf_s;
`endif
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_r;
`endif

    serial_adder_ctrl_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .busy (busy_r),
        .done (done_r)
    );

endmodule
